tx_iq_dac_packer: RTL

// - Downstream of tx_intf's baseband IQ path, in the dac_clk domain: buffers 16-bit I/Q from the OFDM TX accelerator.
// - Applies gain, packs two antenna slots into one 64-bit DAC word and streams it to the DAC core with a valid/ready handshake.
// - Prefills before streaming, inserts zero words on underrun and drains after tx_end.

---
 rtl/tx_iq_dac_packer_if.sv | 10 +
 rtl/tx_iq_dac_packer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_iq_dac_packer_if.sv
// tx_iq_dac_packer_if: valid/ready stream of packed 64-bit DAC words.
// master = packer side (drives valid/data), slave = DAC core side (drives ready).
interface tx_iq_dac_packer_if;
   logic        dac_valid;
   logic [63:0] dac_data;
   logic        dac_ready;

   modport master (output dac_valid, output dac_data, input dac_ready);
   modport slave  (input dac_valid, input dac_data, output dac_ready);
endinterface

// File: rtl/tx_iq_dac_packer.sv
// tx_iq_dac_packer: dac_clk-domain IQ buffer between the OFDM TX accelerator and the DAC core.
// Samples are staged (with optional gain), buffered in a 16-entry FIFO, and streamed as
// 64-bit words {q1,i1,q0,i0} through an IDLE/PREFILL/STREAM/DRAIN controller.
// Optional feature: define TX_IQ_GAIN_EN to enable the saturating gain stage
// (y = sat16((x * tx_gain) >>> 5)); without it samples pass unscaled with the same latency.
module tx_iq_dac_packer #(
   parameter int IQ_WIDTH        = 16,
   parameter int FIFO_DEPTH_LOG2 = 4,
   parameter int PREFILL_TH      = 4
) (
   input  logic                       dac_clk,
   input  logic                       dac_rst,
   input  logic signed [IQ_WIDTH-1:0] rf_i_from_acc,
   input  logic signed [IQ_WIDTH-1:0] rf_q_from_acc,
   input  logic                       rf_iq_valid_from_acc,
   input  logic                       tx_start_from_acc,
   input  logic                       tx_end_from_acc,
   input  logic [1:0]                 ant_sel,
   input  logic [7:0]                 tx_gain,
   tx_iq_dac_packer_if.master         dac,
   output logic                       tx_iq_fifo_empty,
   output logic [2*IQ_WIDTH-1:0]      iq0_for_check,
   output logic [2*IQ_WIDTH-1:0]      iq1_for_check,
   output logic                       iq_valid_for_check,
   output logic                       tx_done,
   output logic [15:0]                underrun_cnt,
   output logic                       overflow
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int CW    = FIFO_DEPTH_LOG2 + 1;
   localparam int SW    = 2 * IQ_WIDTH;
   localparam int WW    = 4 * IQ_WIDTH;

   localparam logic [CW-1:0]              DEPTH_CNT   = CW'(DEPTH);
   localparam logic [CW-1:0]              PREFILL_CNT = CW'(PREFILL_TH);
   localparam logic [CW-1:0]              CNT_ONE     = CW'(1);
   localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE     = FIFO_DEPTH_LOG2'(1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PREFILL = 2'd1;
   localparam logic [1:0] S_STREAM  = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

`ifdef TX_IQ_GAIN_EN
   localparam int PW = IQ_WIDTH + 9;
   localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (IQ_WIDTH - 1)) - 1);
   localparam logic signed [PW-1:0] SAT_MIN = PW'(-(2 ** (IQ_WIDTH - 1)));

   // Signed 16x9 multiply (gain zero-extended), arithmetic >>> 5 so 32 is unity, then clamp.
   function automatic logic signed [IQ_WIDTH-1:0] apply_gain(
      input logic signed [IQ_WIDTH-1:0] x,
      input logic [7:0]                 g
   );
      logic signed [PW-1:0] prod;
      logic signed [PW-1:0] res;
      prod = PW'(x) * PW'($signed({1'b0, g}));
      prod = prod >>> 5;
      if (prod > SAT_MAX) begin
         res = SAT_MAX;
      end else if (prod < SAT_MIN) begin
         res = SAT_MIN;
      end else begin
         res = prod;
      end
      return res[IQ_WIDTH-1:0];
   endfunction
`else
   logic unused_tx_gain;
   assign unused_tx_gain = ^tx_gain;
`endif

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   logic                       stg_valid_q, stg_valid_d;
   logic signed [IQ_WIDTH-1:0] stg_i_q, stg_i_d;
   logic signed [IQ_WIDTH-1:0] stg_q_q, stg_q_d;

   logic [SW-1:0]              fifo_mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]              count_q, count_d;
   logic                       fifo_full, fifo_empty;
   logic                       fifo_wr, fifo_rd, flush;
   logic [SW-1:0]              fifo_head;
   logic [WW-1:0]              head_word;

   logic [1:0]                 state_q, state_d;
   logic                       out_full_q, out_full_d;
   logic [WW-1:0]              out_data_q, out_data_d;
   logic                       accept;

   logic [15:0]                underrun_q, underrun_d;
   logic                       overflow_q, overflow_d;
   logic                       tx_done_q, tx_done_d;
   logic                       chk_valid_q, chk_valid_d;
   logic [SW-1:0]              chk0_q, chk0_d;
   logic [SW-1:0]              chk1_q, chk1_d;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   assign fifo_full  = (count_q == DEPTH_CNT);
   assign fifo_empty = (count_q == '0);
   assign fifo_head  = fifo_mem[rd_ptr_q];
   assign head_word  = {ant_sel[1] ? fifo_head : {SW{1'b0}},
                        ant_sel[0] ? fifo_head : {SW{1'b0}}};
   assign fifo_wr    = stg_valid_q && !fifo_full && !flush;
   assign accept     = out_full_q && dac.dac_ready;

   // Stage the incoming sample, gain applied when the gain stage is built in.
   always_comb begin
      // NOTE: combinational blocks use blocking '='; only always_ff uses '<='.
      stg_valid_d = rf_iq_valid_from_acc;
`ifdef TX_IQ_GAIN_EN
      stg_i_d     = apply_gain(rf_i_from_acc, tx_gain);
      stg_q_d     = apply_gain(rf_q_from_acc, tx_gain);
`else
      stg_i_d     = rf_i_from_acc;
      stg_q_d     = rf_q_from_acc;
`endif
   end

   // Controller: prefill gate, output word selection, underrun/overflow bookkeeping, abort.
   always_comb begin
      // NOTE: every signal gets a default before the case, so no latch is inferred.
      state_d     = state_q;
      out_full_d  = out_full_q;
      out_data_d  = out_data_q;
      fifo_rd     = 1'b0;
      flush       = 1'b0;
      underrun_d  = underrun_q;
      overflow_d  = overflow_q | (stg_valid_q & fifo_full);
      tx_done_d   = 1'b0;
      chk_valid_d = accept;
      chk0_d      = accept ? out_data_q[SW-1:0]  : chk0_q;
      chk1_d      = accept ? out_data_q[WW-1:SW] : chk1_q;

      case (state_q)
         S_IDLE: begin
            if (tx_start_from_acc) begin
               state_d    = S_PREFILL;
               underrun_d = '0;
            end
         end
         S_PREFILL: begin
            if (tx_end_from_acc) begin
               state_d = S_DRAIN;
            end else if (count_q >= PREFILL_CNT) begin
               fifo_rd    = 1'b1;
               out_full_d = 1'b1;
               out_data_d = head_word;
               state_d    = S_STREAM;
            end
         end
         S_STREAM: begin
            if (accept) begin
               if (!fifo_empty) begin
                  fifo_rd    = 1'b1;
                  out_data_d = head_word;
               end else if (tx_end_from_acc) begin
                  // Packet is ending: leave the register empty instead of padding.
                  out_full_d = 1'b0;
                  out_data_d = '0;
               end else begin
                  out_data_d = '0;
                  if (underrun_q != 16'hFFFF) begin
                     underrun_d = underrun_q + 16'd1;
                  end
               end
            end
            if (tx_end_from_acc) begin
               state_d = S_DRAIN;
            end
         end
         default: begin // S_DRAIN
            if (!out_full_q || accept) begin
               if (!fifo_empty) begin
                  fifo_rd    = 1'b1;
                  out_full_d = 1'b1;
                  out_data_d = head_word;
               end else begin
                  out_full_d = 1'b0;
                  out_data_d = '0;
                  // A staged sample still has to land in the FIFO before drain ends.
                  if (!stg_valid_q) begin
                     tx_done_d = 1'b1;
                     state_d   = S_IDLE;
                  end
               end
            end
         end
      endcase

      // Restart mid-packet: drop buffered data and counters; the sample entering the
      // staging register this cycle belongs to the new packet and survives.
      if (tx_start_from_acc && (state_q != S_IDLE)) begin
         flush      = 1'b1;
         fifo_rd    = 1'b0;
         state_d    = S_PREFILL;
         out_full_d = 1'b0;
         out_data_d = '0;
         underrun_d = '0;
         overflow_d = 1'b0;
         tx_done_d  = 1'b0;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (fifo_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (fifo_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({fifo_wr, fifo_rd})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   // All control and datapath flops, cleared asynchronously.
   always_ff @(posedge dac_clk or posedge dac_rst) begin
      if (dac_rst) begin
         stg_valid_q <= 1'b0;
         stg_i_q     <= '0;
         stg_q_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= S_IDLE;
         out_full_q  <= 1'b0;
         out_data_q  <= '0;
         underrun_q  <= '0;
         overflow_q  <= 1'b0;
         tx_done_q   <= 1'b0;
         chk_valid_q <= 1'b0;
         chk0_q      <= '0;
         chk1_q      <= '0;
      end else begin
         stg_valid_q <= stg_valid_d;
         stg_i_q     <= stg_i_d;
         stg_q_q     <= stg_q_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         out_full_q  <= out_full_d;
         out_data_q  <= out_data_d;
         underrun_q  <= underrun_d;
         overflow_q  <= overflow_d;
         tx_done_q   <= tx_done_d;
         chk_valid_q <= chk_valid_d;
         chk0_q      <= chk0_d;
         chk1_q      <= chk1_d;
      end
   end

   // Sample storage write port.
   // NOTE: the array has no reset; the pointers and count alone define what is valid.
   always_ff @(posedge dac_clk) begin
      if (fifo_wr) begin
         fifo_mem[wr_ptr_q] <= {stg_q_q, stg_i_q};
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign dac.dac_valid        = out_full_q;
   assign dac.dac_data         = out_data_q;
   assign tx_iq_fifo_empty     = fifo_empty;
   assign iq0_for_check        = chk0_q;
   assign iq1_for_check        = chk1_q;
   assign iq_valid_for_check   = chk_valid_q;
   assign tx_done              = tx_done_q;
   assign underrun_cnt         = underrun_q;
   assign overflow             = overflow_q;

endmodule
